// File: rtl/dmem_pkg.sv
// Shared address map and decode-select type for the DMEM responder.
package dmem_pkg;

    localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
    localparam logic [31:0] IO_BASE      = 32'h0001_0000;
    localparam logic [31:0] LEDS_OFF     = 32'h0000_0000;
    localparam logic [31:0] SW_OFF       = 32'h0000_0004;
    localparam logic [31:0] MTIME_OFF    = 32'h0000_0008;
    localparam logic [31:0] MTIMECMP_OFF = 32'h0000_000C;

    localparam int LED_W = 10;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_LEDS,
        SEL_SW,
        SEL_MTIME,
        SEL_MTIMECMP,
        SEL_NONE
    } dsel_t;

    function automatic logic [31:0] io_addr(input logic [31:0] off);
        return IO_BASE + off;
    endfunction

endpackage

// File: rtl/io_timer.sv
// Prescaled free-running MTIME with MTIMECMP compare and a sticky level interrupt.
module io_timer #(
    parameter int W        = 32,
    parameter int PRESCALE = 1
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         i_mtime_we,
    input  logic         i_mtimecmp_we,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_mtime,
    output logic [W-1:0] o_mtimecmp,
    output logic         o_irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] r_pre;
    logic [W-1:0]  r_mtime;
    logic [W-1:0]  r_mtimecmp;
    logic          r_irq;
    logic          w_tick;

    assign w_tick = (r_pre == PW'(PRESCALE - 1));

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_pre      <= '0;
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_irq      <= 1'b0;
        end else begin
            if (i_mtime_we) begin
                r_mtime <= i_wdata;
                r_pre   <= '0;
            end else if (w_tick) begin
                r_mtime <= r_mtime + W'(1);
                r_pre   <= '0;
            end else begin
                r_pre   <= r_pre + PW'(1);
            end
            // A compare write drops the interrupt; the new value is judged next edge.
            if (i_mtimecmp_we) begin
                r_mtimecmp <= i_wdata;
                r_irq      <= 1'b0;
            end else if (r_mtime >= r_mtimecmp) begin
                r_irq      <= 1'b1;
            end
        end
    end

    assign o_mtime    = r_mtime;
    assign o_mtimecmp = r_mtimecmp;
    assign o_irq      = r_irq;

endmodule

// File: rtl/dmem_responder.sv
// DMEM bus slave: word RAM plus LED, switch and timer registers, zero-latency reads.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int data_size    = 1024,
    parameter int address_size = 32,
    parameter int PRESCALE     = 1
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [address_size-1:0] daddr,
    input  logic [address_size-1:0] ddata_w,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    output logic [address_size-1:0] ddata_r,
    input  logic [LED_W-1:0]        SW,
    output logic [LED_W-1:0]        LEDS,
    output logic                    irq_timer,
    output logic                    access_fault
);

    localparam int AW = $clog2(data_size);

    logic [address_size-1:0] r_ram [data_size];
    logic [LED_W-1:0]        r_leds;
    logic [LED_W-1:0]        r_sw_meta;
    logic [LED_W-1:0]        r_sw_sync;
    logic                    r_fault;

    dsel_t                   w_sel;
    logic [AW-1:0]           w_idx;
    logic [address_size-1:0] w_rdata;
    logic [address_size-1:0] w_mtime;
    logic [address_size-1:0] w_mtimecmp;
    logic                    w_wr;
    logic                    w_fault;

    assign w_idx = daddr[AW+1:2];

    // Misaligned addresses fall through to SEL_NONE, which suppresses the access.
    always_comb begin
        w_sel = SEL_NONE;
        if (daddr[1:0] == 2'b00) begin
            if (daddr[address_size-1:AW+2] == RAM_BASE[address_size-1:AW+2])
                w_sel = SEL_RAM;
            else if (daddr == address_size'(io_addr(LEDS_OFF)))
                w_sel = SEL_LEDS;
            else if (daddr == address_size'(io_addr(SW_OFF)))
                w_sel = SEL_SW;
            else if (daddr == address_size'(io_addr(MTIME_OFF)))
                w_sel = SEL_MTIME;
            else if (daddr == address_size'(io_addr(MTIMECMP_OFF)))
                w_sel = SEL_MTIMECMP;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            SEL_RAM:      w_rdata = r_ram[w_idx];
            SEL_LEDS:     w_rdata = address_size'(r_leds);
            SEL_SW:       w_rdata = address_size'(r_sw_sync);
            SEL_MTIME:    w_rdata = w_mtime;
            SEL_MTIMECMP: w_rdata = w_mtimecmp;
            default:      w_rdata = '0;
        endcase
    end

    assign ddata_r = MemRead ? w_rdata : '0;
    assign w_wr    = MemWrite & RESET_N;
    assign w_fault = (MemRead | MemWrite) & ((w_sel == SEL_NONE) | (MemRead & MemWrite));

    always_ff @(posedge CLK) begin
        if (w_wr && (w_sel == SEL_RAM))
            r_ram[w_idx] <= ddata_w;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_leds    <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_fault   <= 1'b0;
        end else begin
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
            r_fault   <= w_fault;
            if (w_wr && (w_sel == SEL_LEDS))
                r_leds <= ddata_w[LED_W-1:0];
        end
    end

    io_timer #(
        .W        (address_size),
        .PRESCALE (PRESCALE)
    ) u_io_timer (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .i_mtime_we    (w_wr && (w_sel == SEL_MTIME)),
        .i_mtimecmp_we (w_wr && (w_sel == SEL_MTIMECMP)),
        .i_wdata       (ddata_w),
        .o_mtime       (w_mtime),
        .o_mtimecmp    (w_mtimecmp),
        .o_irq         (irq_timer)
    );

    assign LEDS         = r_leds;
    assign access_fault = r_fault;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, LEDs, switches, timer, faults and reset.
module tb_dmem_responder;

    logic        CLK;
    logic        RESET_N;
    logic [31:0] daddr;
    logic [31:0] ddata_w;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ddata_r;
    logic [9:0]  SW;
    logic [9:0]  LEDS;
    logic        irq_timer;
    logic        access_fault;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] A_LEDS  = 32'h0001_0000;
    localparam logic [31:0] A_SW    = 32'h0001_0004;
    localparam logic [31:0] A_MTIME = 32'h0001_0008;
    localparam logic [31:0] A_CMP   = 32'h0001_000C;

    dmem_responder #(
        .data_size    (1024),
        .address_size (32),
        .PRESCALE     (4)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .daddr        (daddr),
        .ddata_w      (ddata_w),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .ddata_r      (ddata_r),
        .SW           (SW),
        .LEDS         (LEDS),
        .irq_timer    (irq_timer),
        .access_fault (access_fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        daddr    = addr;
        ddata_w  = data;
        MemWrite = 1'b1;
        @(posedge CLK);
        #1;
        MemWrite = 1'b0;
        ddata_w  = '0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        daddr   = addr;
        MemRead = 1'b1;
        @(negedge CLK);
        data = ddata_r;
        @(posedge CLK);
        #1;
        MemRead = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(addr, d);
        check(tag, d, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        RESET_N  = 1'b0;
        daddr    = '0;
        ddata_w  = '0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        SW       = '0;
        idle(3);
        RESET_N = 1'b1;

        // RAM survives a second reset; all other state returns to its reset value.
        bus_wr(32'h10, 32'h1234_5678);
        bus_wr(A_LEDS, 32'h0000_02AA);
        RESET_N = 1'b0;
        idle(2);
        RESET_N = 1'b1;
        check("rst_leds", {22'd0, LEDS}, 32'h0);
        check("rst_irq", {31'd0, irq_timer}, 32'h0);
        check("rst_fault", {31'd0, access_fault}, 32'h0);
        rd_chk("rst_cmp", A_CMP, 32'hFFFF_FFFF);
        rd_chk("ram_keep", 32'h10, 32'h1234_5678);
        daddr = 32'h10;
        #1;
        check("rd_idle", ddata_r, 32'h0);

        // RAM store/load and same-cycle read+write
        bus_wr(32'h44, 32'hA5A5_0044);
        bus_wr(32'h40, 32'hDEAD_BEEF);
        rd_chk("ram_40", 32'h40, 32'hDEAD_BEEF);
        rd_chk("ram_44", 32'h44, 32'hA5A5_0044);
        daddr    = 32'h44;
        ddata_w  = 32'h0BAD_F00D;
        MemRead  = 1'b1;
        MemWrite = 1'b1;
        @(negedge CLK);
        check("rw_old", ddata_r, 32'hA5A5_0044);
        @(posedge CLK);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        check("rw_fault", {31'd0, access_fault}, 32'h1);
        rd_chk("rw_new", 32'h44, 32'h0BAD_F00D);
        check("rw_fault_end", {31'd0, access_fault}, 32'h0);

        // LEDs
        bus_wr(A_LEDS, 32'h0000_03FF);
        check("leds_3ff", {22'd0, LEDS}, 32'h3FF);
        rd_chk("leds_rd", A_LEDS, 32'h0000_03FF);
        bus_wr(A_LEDS, 32'hFFFF_FC00);
        check("leds_hi", {22'd0, LEDS}, 32'h0);

        // Timer, prescale 4; edge E0 is the MTIME write
        bus_wr(A_MTIME, 32'hFFFF_FFFE);
        bus_wr(A_CMP, 32'h0000_0001);
        idle(3);
        rd_chk("mtime_e4", A_MTIME, 32'hFFFF_FFFF);
        idle(3);
        check("irq_big", {31'd0, irq_timer}, 32'h1);
        rd_chk("mtime_wrap", A_MTIME, 32'h0);
        bus_wr(A_CMP, 32'h0000_0001);
        check("irq_clr", {31'd0, irq_timer}, 32'h0);
        idle(2);
        check("irq_low", {31'd0, irq_timer}, 32'h0);
        rd_chk("mtime_e12", A_MTIME, 32'h1);
        check("irq_rise", {31'd0, irq_timer}, 32'h1);
        bus_wr(A_CMP, 32'd100);
        check("irq_cmp100", {31'd0, irq_timer}, 32'h0);
        idle(1);
        check("irq_stay", {31'd0, irq_timer}, 32'h0);
        rd_chk("cmp_rd", A_CMP, 32'd100);

        // Faults
        bus_rd(32'h42, d);
        check("mis_rd", d, 32'h0);
        check("mis_fault", {31'd0, access_fault}, 32'h1);
        idle(1);
        check("mis_fault_end", {31'd0, access_fault}, 32'h0);
        bus_wr(32'h41, 32'h0000_0055);
        check("mis_wr_fault", {31'd0, access_fault}, 32'h1);
        rd_chk("mis_wr_drop", 32'h40, 32'hDEAD_BEEF);
        bus_rd(32'h0002_0000, d);
        check("unmap_rd", d, 32'h0);
        check("unmap_fault", {31'd0, access_fault}, 32'h1);
        bus_wr(A_SW, 32'h0000_03FF);
        check("sw_wr_nofault", {31'd0, access_fault}, 32'h0);
        rd_chk("sw_wr_ign", A_SW, 32'h0);

        // Reset on the same edge as a store drops the store
        bus_wr(32'h80, 32'h1111_2222);
        bus_wr(A_LEDS, 32'h0000_0155);
        daddr    = 32'h80;
        ddata_w  = 32'h0000_0BAD;
        MemWrite = 1'b1;
        RESET_N  = 1'b0;
        @(posedge CLK);
        #1;
        MemWrite = 1'b0;
        RESET_N  = 1'b1;
        rd_chk("rst_drop", 32'h80, 32'h1111_2222);
        check("rst2_leds", {22'd0, LEDS}, 32'h0);
        rd_chk("rst2_cmp", A_CMP, 32'hFFFF_FFFF);

        // Switch synchroniser: two edges of latency
        SW = 10'h155;
        idle(1);
        rd_chk("sw_1edge", A_SW, 32'h0);
        rd_chk("sw_2edge", A_SW, 32'h0000_0155);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
